// File: rtl/elevator_request_queue.sv
// elevator_request_queue: car-call request queue for one elevator car.
// Latency: a request sets queue_status one cycle after it is sampled; target/direction follow one cycle later.
// Backpressure: none. Requests are always accepted; repeats are no-ops, or cancel the call when ELEVATOR_QUEUE_CANCEL_EN is defined.
//
// Ports:
//   clk, reset          - clock and asynchronous active-high reset
//   request_valid       - requested_floor carries a new car call this cycle
//   requested_floor[2:0]- floor index of the car call
//   current_floor[2:0]  - floor the car is at or passing
//   arrived             - one-cycle pulse: car stopped at current_floor
//   queue_status[7:0]   - registered pending map (bit n = floor n pending)
//   target_floor[2:0]   - registered next destination
//   target_valid        - registered, target_floor is meaningful
//   direction[1:0]      - registered FSM state: 00 IDLE, 01 UP, 10 DOWN
//
// Optional feature: `define ELEVATOR_QUEUE_CANCEL_EN to let a second press
// of a lit button cancel that call.

module elevator_request_queue (
  input  logic       clk,
  input  logic       reset,
  input  logic       request_valid,
  input  logic [2:0] requested_floor,
  input  logic [2:0] current_floor,
  input  logic       arrived,
  output logic [7:0] queue_status,
  output logic [2:0] target_floor,
  output logic       target_valid,
  output logic [1:0] direction
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10
  } dir_t;

  dir_t state;
  dir_t state_nxt;

  logic [7:0] pending_nxt;
  logic       here;
  logic       above;
  logic       below;
  logic [2:0] lowest_up;     // lowest pending floor >= current_floor
  logic [2:0] highest_down;  // highest pending floor <= current_floor
  logic [2:0] target_nxt;

  // Pending map update. Arrival clear always wins over a same-cycle set,
  // so a call for the floor the car is standing at is dropped as serviced.
  always_comb begin
    pending_nxt = queue_status;
    for (int i = 0; i < 8; i++) begin
      if (arrived && current_floor == 3'(i)) begin
        pending_nxt[i] = 1'b0;
      end else if (request_valid && requested_floor == 3'(i)) begin
`ifdef ELEVATOR_QUEUE_CANCEL_EN
        pending_nxt[i] = ~queue_status[i];
`else
        pending_nxt[i] = 1'b1;
`endif
      end
    end
  end

  // Position of the pending calls relative to the car, plus the nearest
  // call in each sweep direction (the car's own floor counts for both).
  always_comb begin
    here         = queue_status[current_floor];
    above        = 1'b0;
    below        = 1'b0;
    lowest_up    = current_floor;
    highest_down = current_floor;
    for (int i = 7; i >= 0; i--) begin
      if (queue_status[i] && 3'(i) >= current_floor) lowest_up = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      if (queue_status[i] && 3'(i) <= current_floor) highest_down = 3'(i);
      if (queue_status[i] && 3'(i) > current_floor)  above = 1'b1;
      if (queue_status[i] && 3'(i) < current_floor)  below = 1'b1;
    end
  end

  // Direction decision. IDLE prefers UP when calls exist on both sides;
  // a moving car keeps its direction while calls remain ahead or here.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (here)       state_nxt = ST_IDLE;
        else if (above) state_nxt = ST_UP;
        else if (below) state_nxt = ST_DOWN;
        else            state_nxt = ST_IDLE;
      end
      ST_UP: begin
        if (here || above) state_nxt = ST_UP;
        else if (below)    state_nxt = ST_DOWN;
        else               state_nxt = ST_IDLE;
      end
      ST_DOWN: begin
        if (here || below) state_nxt = ST_DOWN;
        else if (above)    state_nxt = ST_UP;
        else               state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    target_nxt = target_floor;
    case (state_nxt)
      ST_UP:   target_nxt = lowest_up;
      ST_DOWN: target_nxt = highest_down;
      default: if (here) target_nxt = current_floor;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      queue_status <= 8'h00;
    end else begin
      queue_status <= pending_nxt;
    end
  end

  // Every non-empty map yields a target in some direction, so validity is
  // simply "anything pending"; with nothing pending the target holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      target_floor <= 3'd0;
      target_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      target_valid <= |queue_status;
      if (|queue_status) target_floor <= target_nxt;
    end
  end

  assign direction = state;

endmodule
